// File: rtl/readback_uart_tx_pkg.sv
// Shared 8N1 UART definitions: TX state encoding and frame shape constants.
package readback_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/readback_uart_tx_byte_fifo.sv
// Byte-wide circular FIFO with registered level/full/empty and a drop flag
// for pushes that arrive while full with no pop in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               push_data,
    output logic [7:0]               head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_pop;
    logic          accept;
    logic [LW-1:0] level_nxt;

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign do_pop    = pop && !empty;
    assign accept    = push && (!full || do_pop);
    assign drop      = push && full && !do_pop;
    assign head_data = mem[rptr];
    assign level_nxt = level + LW'(accept) - LW'(do_pop);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (accept) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/readback_uart_tx.sv
// Read-response byte buffer and 8N1 UART transmitter for the host link.
//
//   state    | meaning
//   ST_IDLE  | line high, waiting for a buffered byte
//   ST_START | driving the start bit (low)
//   ST_DATA  | shifting data bits out LSB first
//   ST_STOP  | driving the stop bit(s); chains straight into the next frame
module readback_uart_tx
    import readback_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int RD_LAT       = 1
) (
    input  logic                          clk,
    input  logic                          reset_in,
    input  logic                          ten,
    input  logic [7:0]                    rd_data,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    logic        push_v;
    logic        pop;
    logic        drop;
    logic [7:0]  head_data;

    uart_state_t state, state_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          tx_nxt;
    logic          baud_tc;

    // Align the strobe with the BRAM output so rd_data is captured when valid.
    generate
        if (RD_LAT == 0) begin : g_no_dly
            assign push_v = ten;
        end else if (RD_LAT == 1) begin : g_dly1
            logic ten_q;
            always_ff @(posedge clk) begin
                if (reset_in) ten_q <= 1'b0;
                else          ten_q <= ten;
            end
            assign push_v = ten_q;
        end else begin : g_dlyn
            logic [RD_LAT-1:0] ten_q;
            always_ff @(posedge clk) begin
                if (reset_in) ten_q <= '0;
                else          ten_q <= {ten_q[RD_LAT-2:0], ten};
            end
            assign push_v = ten_q[RD_LAT-1];
        end
    endgenerate

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset_in),
        .push      (push_v),
        .pop       (pop),
        .push_data (rd_data),
        .head_data (head_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (drop)
    );

    assign baud_tc = (baud_cnt == '0);
    assign tx_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            tx        <= tx_nxt;
            overflow  <= overflow | drop;
        end
    end

    // tx_nxt is the line level for the state being entered, so tx stays a flop.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        tx_nxt    = tx;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = head_data;
                    baud_nxt  = BAUD_LOAD;
                    state_nxt = ST_START;
                    tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_tc) begin
                    baud_nxt  = BAUD_LOAD;
                    bit_nxt   = '0;
                    state_nxt = ST_DATA;
                    tx_nxt    = shift_reg[0];
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_tc) begin
                    baud_nxt = BAUD_LOAD;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = ST_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt   = bit_cnt + 3'd1;
                        shift_nxt = shift_reg >> 1;
                        tx_nxt    = shift_reg[1];
                    end
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_tc) begin
                    baud_nxt = BAUD_LOAD;
                    if (bit_cnt == STOP_LAST) begin
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            shift_nxt = head_data;
                            state_nxt = ST_START;
                            tx_nxt    = 1'b0;
                        end else begin
                            state_nxt = ST_IDLE;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule
